// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - start/busy/done request and result bundle for muldiv_unit
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit; MULDIV_FAST_SPECIAL_EN enables early-out corner cases
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          resetn,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            neg_q;
    logic            spec_q;
    logic [XLEN-1:0] spec_val;
    logic [XLEN-1:0] result_q;

    logic            is_div;
    logic            a_sgn;
    logic            b_sgn;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            neg_now;
    logic            spec_now;
    logic [XLEN-1:0] spec_now_val;
    logic            accept;

    // Operand decode at the start-sampling edge
    always_comb begin
        is_div   = bus.op[2];
        a_sgn    = (bus.op != 3'b011) && (bus.op != 3'b101) && (bus.op != 3'b111);
        b_sgn    = (bus.op[1:0] == 2'b00) || (bus.op == 3'b001) || (bus.op == 3'b110);
        a_neg    = a_sgn && bus.a[XLEN-1];
        b_neg    = b_sgn && bus.b[XLEN-1];
        a_mag    = a_neg ? -bus.a : bus.a;
        b_mag    = b_neg ? -bus.b : bus.b;
        neg_now  = (is_div && bus.op[1]) ? a_neg : (a_neg ^ b_neg);
        spec_now = 1'b0;
        spec_now_val = '0;
        if (is_div && (bus.b == '0)) begin
            spec_now     = 1'b1;
            spec_now_val = bus.op[1] ? bus.a : '1;
        end else if (is_div && !bus.op[0] && (bus.a == MOST_NEG) && (bus.b == '1)) begin
            spec_now     = 1'b1;
            spec_now_val = bus.op[1] ? '0 : bus.a;
        end
`ifdef MULDIV_FAST_SPECIAL_EN
        else if (!is_div && (bus.b == '0)) begin
            spec_now     = 1'b1;
            spec_now_val = '0;
        end
`endif
        accept = bus.start && !((state == S_IDLE) && bus.flush);
    end

    logic [XLEN:0]     sum;
    logic [XLEN:0]     part;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   hi_nx;
    logic [XLEN-1:0]   lo_nx;
    logic [2*XLEN-1:0] full;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   dval;
    logic [XLEN-1:0]   fin;

    // One shift-add or restoring-divide step; {hi,lo} is product or {remainder,quotient}
    always_comb begin
        sum   = '0;
        part  = {hi, lo[XLEN-1]};
        diff  = part - {1'b0, mcand};
        hi_nx = hi;
        lo_nx = lo;
        if (!op_q[2]) begin
            sum            = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
            {hi_nx, lo_nx} = {sum, lo[XLEN-1:1]};
        end else if (part >= {1'b0, mcand}) begin
            hi_nx = diff[XLEN-1:0];
            lo_nx = {lo[XLEN-2:0], 1'b1};
        end else begin
            hi_nx = part[XLEN-1:0];
            lo_nx = {lo[XLEN-2:0], 1'b0};
        end

        full = {hi_nx, lo_nx};
        prod = neg_q ? -full : full;
        dval = op_q[1] ? hi_nx : lo_nx;
        if (spec_q) begin
            fin = spec_val;
        end else if (!op_q[2]) begin
            fin = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            fin = neg_q ? -dval : dval;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            mcand    <= '0;
            hi       <= '0;
            lo       <= '0;
            neg_q    <= 1'b0;
            spec_q   <= 1'b0;
            spec_val <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_CALC: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        hi  <= hi_nx;
                        lo  <= lo_nx;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(XLEN - 1)) begin
                            state    <= S_DONE;
                            result_q <= fin;
                        end
                    end
                end
                default: begin
                    if (accept) begin
                        op_q     <= bus.op;
                        mcand    <= is_div ? b_mag : a_mag;
                        hi       <= '0;
                        lo       <= is_div ? a_mag : b_mag;
                        neg_q    <= neg_now;
                        spec_q   <= spec_now;
                        spec_val <= spec_now_val;
                        cnt      <= '0;
                        state    <= S_CALC;
`ifdef MULDIV_FAST_SPECIAL_EN
                        if (spec_now) begin
                            state    <= S_DONE;
                            result_q <= spec_now_val;
                        end
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy   = (state == S_CALC);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit at XLEN 32 and 16
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) b32 ();
    muldiv_unit_if #(.XLEN(16)) b16 ();

    muldiv_unit #(.XLEN(32)) u32 (.clk(clk), .resetn(resetn), .bus(b32));
    muldiv_unit #(.XLEN(16)) u16 (.clk(clk), .resetn(resetn), .bus(b16));

`ifdef MULDIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 0;
`else
    localparam int SPEC_LAT = 32;
`endif

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int bc);
        @(posedge clk); #1;
        b32.start = 1'b1; b32.op = op; b32.a = a; b32.b = b;
        @(posedge clk); #1;
        b32.start = 1'b0;
        lat = 0; bc = 0;
        while (!b32.done && lat < 200) begin
            if (b32.busy) bc++;
            @(posedge clk); #1;
            lat++;
        end
        res = b32.result;
    endtask

    task automatic op32(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int lat, bc;
        run32(op, a, b, res, lat, bc);
        chk({tag, "_res"}, 64'(res), 64'(exp));
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        logic [31:0] res;
        int lat, bc, cnt_done, cnt_busy;

        b32.start = 0; b32.op = 0; b32.a = 0; b32.b = 0; b32.flush = 0;
        b16.start = 0; b16.op = 0; b16.a = 0; b16.b = 0; b16.flush = 0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        chk("rst_busy32", 64'(b32.busy), 64'd0);
        chk("rst_done32", 64'(b32.done), 64'd0);
        chk("rst_res32", 64'(b32.result), 64'd0);
        chk("rst_res16", 64'(b16.result), 64'd0);

        run32(MUL, 32'd7, 32'hFFFF_FFFD, res, lat, bc);
        chk("mul_res", 64'(res), 64'hFFFF_FFEB);
        chk("mul_lat", 64'(lat), 64'd32);
        chk("mul_busy_cycles", 64'(bc), 64'd32);

        op32("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
        op32("mulh", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32);
        op32("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
        op32("div", DIV, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 32);
        op32("rem", REM, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 32);
        op32("divu", DIVU, 32'd20, 32'd6, 32'd3, 32);
        op32("remu", REMU, 32'd20, 32'd6, 32'd2, 32);
        op32("divu_z", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
        op32("rem_z", REM, 32'd5, 32'd0, 32'd5, SPEC_LAT);
        op32("div_z_neg", DIV, 32'hFFFF_FFEC, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
        op32("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
        op32("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPEC_LAT);

        // start pulsed mid-operation with different operands must be ignored
        @(posedge clk); #1;
        b32.start = 1'b1; b32.op = MUL; b32.a = 32'd3; b32.b = 32'd5;
        @(posedge clk); #1;
        b32.start = 1'b0;
        lat = 0;
        while (!b32.done && lat < 200) begin
            if (lat == 5) begin
                b32.start = 1'b1; b32.op = DIVU; b32.a = 32'd100; b32.b = 32'd7;
            end else begin
                b32.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        b32.start = 1'b0;
        chk("ign_res", 64'(b32.result), 64'd15);
        chk("ign_lat", 64'(lat), 64'd32);
        cnt_done = 0; cnt_busy = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (b32.done) cnt_done++;
            if (b32.busy) cnt_busy++;
        end
        chk("ign_no_extra_busy", 64'(cnt_busy), 64'd0);
        chk("ign_no_extra_done", 64'(cnt_done), 64'd0);

        // flush at iteration 10
        @(posedge clk); #1;
        b32.start = 1'b1; b32.op = DIVU; b32.a = 32'd100; b32.b = 32'd7;
        @(posedge clk); #1;
        b32.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        b32.flush = 1'b1;
        @(posedge clk); #1;
        b32.flush = 1'b0;
        chk("flush_busy", 64'(b32.busy), 64'd0);
        cnt_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (b32.done) cnt_done++;
        end
        chk("flush_no_done", 64'(cnt_done), 64'd0);
        chk("flush_res_kept", 64'(b32.result), 64'd15);

        // flush together with start in IDLE drops the start
        b32.start = 1'b1; b32.flush = 1'b1; b32.op = MUL; b32.a = 32'd2; b32.b = 32'd2;
        @(posedge clk); #1;
        b32.start = 1'b0; b32.flush = 1'b0;
        chk("flush_start_idle", 64'(b32.busy), 64'd0);

        // asynchronous reset at iteration 5
        b32.start = 1'b1; b32.op = MUL; b32.a = 32'd7; b32.b = 32'd3;
        @(posedge clk); #1;
        b32.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("pre_rst_busy", 64'(b32.busy), 64'd1);
        resetn = 1'b0;
        #1;
        chk("arst_busy", 64'(b32.busy), 64'd0);
        chk("arst_done", 64'(b32.done), 64'd0);
        chk("arst_res", 64'(b32.result), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        op32("post_rst_divu", DIVU, 32'd20, 32'd6, 32'd3, 32);

        // XLEN=16 back-to-back, start held through the done cycle
        b16.op = MUL; b16.a = 16'h00FF; b16.b = 16'h0101; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0;
        lat = 0;
        while (!b16.done && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("b2b_lat1", 64'(lat), 64'd16);
        chk("b2b_mul", 64'(b16.result), 64'h0000_FFFF);
        b16.start = 1'b1; b16.op = MULHU;
        @(posedge clk); #1;
        b16.start = 1'b0;
        chk("b2b_accept_busy", 64'(b16.busy), 64'd1);
        lat = 0;
        while (!b16.done && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("b2b_lat2", 64'(lat), 64'd16);
        chk("b2b_mulhu", 64'(b16.result), 64'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
